// File: rtl/sprdma.sv
// sprdma: sprite DMA engine. A CPU write to 0x4014 starts a 256-byte copy
// from CPU page {page,00}..{page,FF} to 0x2004, halting the CPU meanwhile.
// Every DMA step advances only on a cpu_ce_in pulse.
// Build option: define SPRDMA_ALIGN_EN to insert one ALIGN step after the
// trigger (513 ce pulses per transfer instead of 512).
`timescale 1ns/1ps
module sprdma (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        cpu_ce_in,
    input  logic [15:0] cpu_a_in,
    input  logic [7:0]  cpu_d_in,
    input  logic        cpu_r_nw_in,
    output logic        cpu_rdy_out,
    input  logic [7:0]  mem_d_in,
    output logic        dma_active_out,
    output logic [15:0] dma_a_out,
    output logic [7:0]  dma_d_out,
    output logic        dma_r_nw_out
);

    localparam logic [15:0] TRIG_ADDR     = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_ALIGN = 2'd1,
        S_RD    = 2'd2,
        S_WR    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  data_q, data_d;

    logic        cpu_rdy_q, cpu_rdy_d;
    logic        dma_active_q, dma_active_d;
    logic [15:0] dma_a_q, dma_a_d;
    logic [7:0]  dma_d_q, dma_d_d;
    logic        dma_r_nw_q, dma_r_nw_d;

    logic        trigger;

    // Start condition: a CPU write to 0x4014 on a ce pulse while idle.
    always_comb begin
        trigger = cpu_ce_in && !cpu_r_nw_in && (cpu_a_in == TRIG_ADDR) &&
                  (state_q == S_READY);
    end

    // Next-state, page/index/data register update.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        data_d  = data_q;
        case (state_q)
            S_READY: begin
                if (trigger) begin
                    page_d  = cpu_d_in;
                    index_d = '0;
`ifdef SPRDMA_ALIGN_EN
                    state_d = S_ALIGN;
`else
                    state_d = S_RD;
`endif
                end
            end
            S_ALIGN: begin
`ifdef SPRDMA_ALIGN_EN
                if (cpu_ce_in) begin
                    state_d = S_RD;
                end
`else
                state_d = S_READY;
`endif
            end
            S_RD: begin
                if (cpu_ce_in) begin
                    data_d  = mem_d_in;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (cpu_ce_in) begin
                    if (index_q == 8'hFF) begin
                        state_d = S_READY;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = S_RD;
                    end
                end
            end
            default: state_d = S_READY;
        endcase
    end

    // Output values for the state being entered, so the bus outputs are flops.
    always_comb begin
        cpu_rdy_d    = 1'b1;
        dma_active_d = 1'b0;
        dma_a_d      = '0;
        dma_d_d      = '0;
        dma_r_nw_d   = 1'b1;
        case (state_d)
            S_ALIGN: begin
                cpu_rdy_d    = 1'b0;
                dma_active_d = 1'b1;
            end
            S_RD: begin
                cpu_rdy_d    = 1'b0;
                dma_active_d = 1'b1;
                dma_a_d      = {page_d, index_d};
            end
            S_WR: begin
                cpu_rdy_d    = 1'b0;
                dma_active_d = 1'b1;
                dma_a_d      = OAM_DATA_ADDR;
                dma_d_d      = data_d;
                dma_r_nw_d   = 1'b0;
            end
            default: begin
                cpu_rdy_d    = 1'b1;
                dma_active_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= S_READY;
            page_q       <= '0;
            index_q      <= '0;
            data_q       <= '0;
            cpu_rdy_q    <= 1'b1;
            dma_active_q <= 1'b0;
            dma_a_q      <= '0;
            dma_d_q      <= '0;
            dma_r_nw_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            index_q      <= index_d;
            data_q       <= data_d;
            cpu_rdy_q    <= cpu_rdy_d;
            dma_active_q <= dma_active_d;
            dma_a_q      <= dma_a_d;
            dma_d_q      <= dma_d_d;
            dma_r_nw_q   <= dma_r_nw_d;
        end
    end

    assign cpu_rdy_out    = cpu_rdy_q;
    assign dma_active_out = dma_active_q;
    assign dma_a_out      = dma_a_q;
    assign dma_d_out      = dma_d_q;
    assign dma_r_nw_out   = dma_r_nw_q;

endmodule

// File: tb/tb_sprdma.sv
// tb_sprdma: randomized-gap DMA transfers checked against a byte-copy model
// of the CPU page (reads {page,i}, writes mem[{page,i}] to 0x2004).
`timescale 1ns/1ps
module tb_sprdma;

`ifdef SPRDMA_ALIGN_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic [15:0] cpu_a = '0;
    logic [7:0]  cpu_d = '0;
    logic        cpu_rnw = 1'b1;
    logic        cpu_rdy;
    logic [7:0]  mem_d;
    logic        dma_active;
    logic [15:0] dma_a;
    logic [7:0]  dma_d;
    logic        dma_rnw;

    logic [7:0]  mem [0:65535];
    int          total = 0;
    int          bad = 0;
    logic [15:0] rd_log [$];
    logic [15:0] wa_log [$];
    logic [7:0]  wd_log [$];
    int          low_ce = 0;

    always #10 clk = ~clk;

    assign mem_d = mem[dma_a];

    sprdma dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .cpu_ce_in      (ce),
        .cpu_a_in       (cpu_a),
        .cpu_d_in       (cpu_d),
        .cpu_r_nw_in    (cpu_rnw),
        .cpu_rdy_out    (cpu_rdy),
        .mem_d_in       (mem_d),
        .dma_active_out (dma_active),
        .dma_a_out      (dma_a),
        .dma_d_out      (dma_d),
        .dma_r_nw_out   (dma_rnw)
    );

    // Bus monitor: every ce pulse while the DMA owns the bus is one access.
    always @(posedge clk) begin
        if (rst_n && ce) begin
            if (!cpu_rdy) low_ce++;
            if (dma_active) begin
                if (dma_rnw) begin
                    rd_log.push_back(dma_a);
                end else begin
                    wa_log.push_back(dma_a);
                    wd_log.push_back(dma_d);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One ce pulse carrying a CPU bus cycle; starts and ends at a negedge.
    task automatic pulse(input logic [15:0] a, input logic rnw, input logic [7:0] d, input int gap);
        ce = 1'b1; cpu_a = a; cpu_rnw = rnw; cpu_d = d;
        @(negedge clk);
        ce = 1'b0; cpu_a = '0; cpu_rnw = 1'b1; cpu_d = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"},    32'(cpu_rdy),    32'd1);
        chk({tag, "_active"}, 32'(dma_active), 32'd0);
        chk({tag, "_addr"},   32'(dma_a),      32'd0);
        chk({tag, "_data"},   32'(dma_d),      32'd0);
        chk({tag, "_rnw"},    32'(dma_rnw),    32'd1);
    endtask

    // hook: 0 none, 1 ce gap at RD 0x40, 2 retrigger at WR 0x10, 3 reset at 0x80.
    // gmode < 0 picks a random gap per pulse.
    task automatic xfer(input logic [7:0] page, input int gmode, input int hook);
        int rd0, wr0, ce0, nbytes, gap;
        bit aborted;
        logic [15:0] exp_a;
        aborted = 1'b0;
        rd0 = rd_log.size(); wr0 = wa_log.size(); ce0 = low_ce;
        gap = (gmode < 0) ? int'($urandom_range(0, 3)) : gmode;
        pulse(16'h4014, 1'b0, page, 0);
        chk("trig_rdy_low", 32'(cpu_rdy), 32'd0);
        chk("trig_active", 32'(dma_active), 32'd1);
        repeat (gap) @(negedge clk);
        for (int k = 0; k < 512 + EXTRA; k++) begin
            gap = (gmode < 0) ? int'($urandom_range(0, 3)) : gmode;
            if (hook == 1 && k == EXTRA + 2 * 'h40) begin
                for (int s = 0; s < 20; s++) begin
                    chk("gap_addr", 32'(dma_a), 32'({page, 8'h40}));
                    chk("gap_rnw", 32'(dma_rnw), 32'd1);
                    @(negedge clk);
                end
            end
            if (hook == 2 && k == EXTRA + 2 * 'h10 + 1) begin
                chk("retrig_in_wr", 32'(dma_a), 32'h2004);
                pulse(16'h4014, 1'b0, 8'h07, gap);
            end else if (hook == 3 && k == EXTRA + 2 * 'h80) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk_idle("rst_mid");
                aborted = 1'b1;
                break;
            end else begin
                pulse(16'h0000, 1'b1, 8'h00, gap);
            end
        end
        nbytes = aborted ? 'h80 : 256;
        if (aborted) begin
            repeat (10) pulse(16'h0000, 1'b1, 8'h00, 1);
            chk("post_rst_rdy", 32'(cpu_rdy), 32'd1);
        end
        chk("rd_count", 32'(rd_log.size() - rd0), 32'(nbytes + EXTRA));
        chk("wr_count", 32'(wa_log.size() - wr0), 32'(nbytes));
        for (int i = 0; i < nbytes + EXTRA; i++) begin
            if (rd0 + i < rd_log.size()) begin
                exp_a = (i < EXTRA) ? 16'h0000 : {page, 8'(i - EXTRA)};
                chk("rd_addr", 32'(rd_log[rd0 + i]), 32'(exp_a));
            end
        end
        for (int i = 0; i < nbytes; i++) begin
            if (wr0 + i < wa_log.size()) begin
                chk("wr_addr", 32'(wa_log[wr0 + i]), 32'h2004);
                chk("wr_data", 32'(wd_log[wr0 + i]), 32'(mem[{page, 8'(i)}]));
            end
        end
        if (!aborted) begin
            if (rd_log.size() > rd0)
                chk("last_rd", 32'(rd_log[rd_log.size() - 1]), 32'({page, 8'hFF}));
            chk("ce_low_count", 32'(low_ce - ce0), 32'(512 + EXTRA));
            chk_idle("done");
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[{8'h02, 8'(i)}] = 8'(i) ^ 8'h5A;

        // Reset, with a trigger-shaped write held during reset.
        @(negedge clk);
        ce = 1'b1; cpu_a = 16'h4014; cpu_rnw = 1'b0; cpu_d = 8'h02;
        repeat (3) @(negedge clk);
        ce = 1'b0; cpu_a = '0; cpu_rnw = 1'b1; cpu_d = '0;
        chk_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("after_reset");

        // Non-triggers.
        pulse(16'h4014, 1'b1, 8'h02, 1);
        chk("nt_read_rdy", 32'(cpu_rdy), 32'd1);
        pulse(16'h4015, 1'b0, 8'h02, 1);
        chk("nt_4015_rdy", 32'(cpu_rdy), 32'd1);
        ce = 1'b0; cpu_a = 16'h4014; cpu_rnw = 1'b0; cpu_d = 8'h02;
        @(negedge clk);
        cpu_a = '0; cpu_rnw = 1'b1; cpu_d = '0;
        @(negedge clk);
        chk("nt_noce_rdy", 32'(cpu_rdy), 32'd1);
        chk("nt_noce_active", 32'(dma_active), 32'd0);

        xfer(8'h02, 2, 0);                           // basic, ce every 3 clk
        xfer(8'h02, -1, 1);                          // long ce gap
        xfer(8'h02, -1, 2);                          // retrigger ignored
        xfer(8'($urandom_range(3, 254)), -1, 3);     // reset mid-transfer
        xfer(8'hFF, -1, 0);                          // top page, no wrap
        xfer(8'($urandom_range(0, 255)), -1, 0);     // random page

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprdma.md
SPRDMA -- requirements
Module: sprdma

Interface
REQ-001 The block SHALL have one clock and one reset, with the ports listed below.
- clk_in  input  1  50MHz system clock.
- rst_n_in  input  1  reset; synchronous, active-low.
REQ-002 The block SHALL have the following CPU-side ports.
- cpu_ce_in  input  1  one-clk CPU cycle-enable pulse; every DMA step advances only on this pulse.
- cpu_a_in  input  16  CPU address bus.
- cpu_d_in  input  8  CPU write data.
- cpu_r_nw_in  input  1  CPU read/write (1 = read).
- cpu_rdy_out  output  1  CPU ready; low halts the CPU.
REQ-003 The block SHALL have the following DMA bus ports.
- mem_d_in  input  8  read data returned for the DMA read address.
- dma_active_out  output  1  high while the DMA owns the CPU bus (bus mux select).
- dma_a_out  output  16  DMA bus address.
- dma_d_out  output  8  DMA write data.
- dma_r_nw_out  output  1  DMA read/write (1 = read).

Function
REQ-004 A trigger SHALL be a clk edge with cpu_ce_in=1, cpu_r_nw_in=0, cpu_a_in=16'h4014 and state READY; any other combination is not a trigger.
REQ-005 On a trigger, the block SHALL latch cpu_d_in into the page register, clear the 8-bit index, and enter RD (or ALIGN, see REQ-014) on the next clk.
REQ-006 States SHALL be READY, ALIGN, RD and WR; a transition SHALL occur only on a clk edge with cpu_ce_in=1. Between pulses all outputs SHALL hold.
REQ-007 In RD the outputs SHALL be: dma_a_out={page,index}, dma_r_nw_out=1, dma_d_out=0. On a ce pulse the block SHALL capture mem_d_in into the data register and go to WR.
REQ-008 In WR the outputs SHALL be: dma_a_out=16'h2004, dma_r_nw_out=0, dma_d_out=data register. On a ce pulse, if index=8'hFF the block SHALL go to READY; otherwise it SHALL increment index by 1 (8-bit) and go to RD.
REQ-009 dma_active_out SHALL be 1 and cpu_rdy_out SHALL be 0 in every state except READY, as registered outputs.
- They SHALL be asserted the clk after the trigger.
- They SHALL be released the clk after the final WR ce pulse.
REQ-010 In READY: dma_a_out=0, dma_d_out=0, dma_r_nw_out=1.
REQ-011 A write to 0x4014 while not READY SHALL be ignored: the page and the transfer are unaffected.
REQ-012 A transfer SHALL move exactly 256 bytes: CPU page addresses {page,00}..{page,FF} in order, to 0x2004. Page 8'hFF SHALL NOT wrap into another page. The 0x2003 pointer is not touched.

Reset
REQ-013 When rst_n_in=0 at a clk edge the block SHALL reset as follows:
- State, index, page and data register go to READY/0/0/0.
- Outputs go to cpu_rdy_out=1, dma_active_out=0, dma_a_out=0, dma_d_out=0, dma_r_nw_out=1.
- This applies mid-transfer as well; a transfer aborted by reset SHALL NOT resume.

Configuration
REQ-014 Macro SPRDMA_ALIGN_EN SHALL select the transfer length.
- Defined: a trigger SHALL enter ALIGN. ALIGN drives the READY bus values with dma_active_out=1 and cpu_rdy_out=0, and moves to RD on the next ce pulse. A transfer then takes 513 ce pulses after the trigger.
- Undefined: ALIGN SHALL be unreachable and a trigger SHALL enter RD directly, giving 512 ce pulses.

Verification
REQ-015 Basic transfer: preload page 0x02 with bytes i^0x5A, write 0x02 to 0x4014, and issue ce every 3 clk.
- Required: 256 writes to 0x2004 carrying data 0x5A,0x5B,...,0xA5 in index order.
- Required: cpu_rdy_out is low for exactly 512 ce pulses (513 with SPRDMA_ALIGN_EN).
REQ-016 ce gaps: hold cpu_ce_in=0 for 20 clk in the middle of RD index 0x40.
- Required: dma_a_out stays 0x0240 and no state change occurs until the next pulse.
REQ-017 Retrigger: write 0x07 to 0x4014 during WR index 0x10 of a page-0x02 transfer.
- Required: the addresses continue at 0x0211, and no page-0x07 access occurs.
REQ-018 Non-triggers:
- A read of 0x4014 SHALL leave cpu_rdy_out=1.
- A write of 0x4015 SHALL leave cpu_rdy_out=1.
- A write of 0x4014 with cpu_ce_in=0 SHALL leave cpu_rdy_out=1.
REQ-019 Reset mid-transfer: assert rst_n_in=0 for 1 clk at index 0x80.
- Required: the next clk shows cpu_rdy_out=1, dma_active_out=0, dma_a_out=0 and dma_r_nw_out=1, and no further 0x2004 writes occur.
REQ-020 Page 0xFF transfer: write 0xFF to 0x4014.
- Required: the last read address is 0xFFFF and the last write goes to 0x2004, followed by READY.
